// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU complete at once with a zero result.
module mult_div_unit #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [WORD_LENGTH-1:0] rs_data,
    input  logic [WORD_LENGTH-1:0] rt_data,
    output logic                   busy,
    output logic                   done,
    output logic                   hilo_we,
    output logic [WORD_LENGTH-1:0] hi_out,
    output logic [WORD_LENGTH-1:0] lo_out,
    output logic [1:0]             state_dbg
);

    localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MUL    = 2'd1;
    localparam logic [1:0] S_DIV    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // Handshake: start is only sampled in IDLE; done/hilo_we pulse for the single
    // FINISH cycle and hi_out/lo_out are valid from that cycle until the next FINISH.

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [WORD_LENGTH-1:0] acc_hi;
    logic [WORD_LENGTH-1:0] acc_lo;
    logic [WORD_LENGTH-1:0] mcand;
    logic                   neg_res;
    logic [WORD_LENGTH-1:0] hi_r;
    logic [WORD_LENGTH-1:0] lo_r;

    // Sign handling: op[0]=0 selects the signed variants; work on magnitudes.
    logic                   rs_neg;
    logic                   rt_neg;
    logic [WORD_LENGTH-1:0] rs_mag;
    logic [WORD_LENGTH-1:0] rt_mag;

    assign rs_neg = ~op[0] & rs_data[WORD_LENGTH-1];
    assign rt_neg = ~op[0] & rt_data[WORD_LENGTH-1];
    assign rs_mag = rs_neg ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;

    // Multiply step: acc_lo holds the multiplier and fills with product bits from the top.
    logic [WORD_LENGTH:0]     mul_sum;
    logic [WORD_LENGTH-1:0]   mul_hi_nx;
    logic [WORD_LENGTH-1:0]   mul_lo_nx;
    logic [2*WORD_LENGTH-1:0] mul_prod;
    logic [2*WORD_LENGTH-1:0] mul_res;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign mul_hi_nx = mul_sum[WORD_LENGTH:1];
    assign mul_lo_nx = {mul_sum[0], acc_lo[WORD_LENGTH-1:1]};
    assign mul_prod  = {mul_hi_nx, mul_lo_nx};
    assign mul_res   = neg_res ? -mul_prod : mul_prod;

`ifdef MDU_DIV_EN
    // Divide step: acc_hi is the partial remainder, acc_lo shifts the dividend out
    // and the quotient in, mcand holds the divisor magnitude.
    logic                   neg_rem;
    logic                   div_zero;
    logic [WORD_LENGTH-1:0] rs_lat;
    logic [WORD_LENGTH:0]   div_shift;
    logic [WORD_LENGTH:0]   div_diff;
    logic                   div_ge;
    logic [WORD_LENGTH-1:0] rem_nx;
    logic [WORD_LENGTH-1:0] quo_nx;
    logic [WORD_LENGTH-1:0] rem_res;
    logic [WORD_LENGTH-1:0] quo_res;

    assign div_shift = {acc_hi, acc_lo[WORD_LENGTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand};
    assign div_ge    = ~div_diff[WORD_LENGTH];
    assign rem_nx    = div_ge ? div_diff[WORD_LENGTH-1:0] : div_shift[WORD_LENGTH-1:0];
    assign quo_nx    = {acc_lo[WORD_LENGTH-2:0], div_ge};
    assign rem_res   = neg_rem ? -rem_nx : rem_nx;
    assign quo_res   = neg_res ? -quo_nx : quo_nx;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            mcand   <= '0;
            neg_res <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
`ifdef MDU_DIV_EN
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            rs_lat   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        acc_hi  <= '0;
                        neg_res <= rs_neg ^ rt_neg;
                        if (!op[1]) begin
                            acc_lo <= rt_mag;
                            mcand  <= rs_mag;
                            state  <= S_MUL;
                        end else begin
`ifdef MDU_DIV_EN
                            acc_lo   <= rs_mag;
                            mcand    <= rt_mag;
                            neg_rem  <= rs_neg;
                            div_zero <= (rt_data == '0);
                            rs_lat   <= rs_data;
                            state    <= S_DIV;
`else
                            hi_r  <= '0;
                            lo_r  <= '0;
                            state <= S_FINISH;
`endif
                        end
                    end
                end
                S_MUL: begin
                    acc_hi <= mul_hi_nx;
                    acc_lo <= mul_lo_nx;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        {hi_r, lo_r} <= mul_res;
                        state        <= S_FINISH;
                    end
                end
                S_DIV: begin
`ifdef MDU_DIV_EN
                    acc_hi <= rem_nx;
                    acc_lo <= quo_nx;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Divide by zero still takes the full iteration count.
                        if (div_zero) begin
                            hi_r <= rs_lat;
                            lo_r <= '1;
                        end else begin
                            hi_r <= rem_res;
                            lo_r <= quo_res;
                        end
                        state <= S_FINISH;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FINISH);
    assign hilo_we   = done;
    assign hi_out    = hi_r;
    assign lo_out    = lo_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed operations with literal results plus an
// arithmetic/latency reference model compared against the outputs on every cycle.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    mult_div_unit #(.WORD_LENGTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .busy      (busy),
        .done      (done),
        .hilo_we   (hilo_we),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .state_dbg (state_dbg)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference arithmetic, written from the architectural definition of each op
    function automatic logic [63:0] model_res(input logic [1:0] mop, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        int ia;
        int ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ia = a;
        ib = b;
        if (mop == 2'b00) return sa * sb;
        if (mop == 2'b01) return {32'h0, a} * {32'h0, b};
        if (!DIV_EN) return 64'h0;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (mop == 2'b10) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(ia % ib), 32'(ia / ib)};
        end
        return {a % b, a / b};
    endfunction

    // behavioural model: remaining-latency counter plus held result
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;
    int          m_left;
    logic        cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = 32'h0;
            m_lo   = 32'h0;
            m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done       = 1'b1;
                {m_hi, m_lo} = m_pend;
            end
        end else if (start) begin
            m_busy = 1'b1;
            m_pend = model_res(op, rs_data, rt_data);
            if (op[1] && !DIV_EN) begin
                m_done       = 1'b1;
                {m_hi, m_lo} = m_pend;
            end else begin
                m_left = 32;
            end
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
            chk("cyc_hilo_we", hilo_we, m_done);
            chk("cyc_hi", hi_out, m_hi);
            chk("cyc_lo", lo_out, m_lo);
        end
    end

    // driver: kind 0 plain, 1 = re-start at iteration 5, 2 = reset at iteration 10
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat, input int kind);
        int   n;
        logic busy_low;
        logic aborted;
        logic saw;
        n        = 0;
        busy_low = 1'b0;
        aborted  = 1'b0;
        saw      = 1'b0;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!done && n < 100 && !aborted) begin
            if (!busy) busy_low = 1'b1;
            if (kind == 1 && n == 5) begin
                start   = 1'b1;
                op      = 2'b00;
                rs_data = 32'hFFFF_FFFF;
                rt_data = 32'h0000_0002;
            end
            if (kind == 1 && n == 6) start = 1'b0;
            if (kind == 2 && n == 10) reset = 1'b0;
            @(posedge clk);
            n++;
            #1;
            if (kind == 2 && n == 11) begin
                chk({name, "_abort_busy"}, busy, 1'b0);
                chk({name, "_abort_hi"}, hi_out, 32'h0);
                chk({name, "_abort_lo"}, lo_out, 32'h0);
                reset   = 1'b1;
                aborted = 1'b1;
            end
        end
        if (kind == 2) begin
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (done || hilo_we) saw = 1'b1;
            end
            chk({name, "_no_done"}, saw, 1'b0);
        end else begin
            chk({name, "_latency"}, n, exp_lat);
            chk({name, "_busy_held"}, busy_low, 1'b0);
            chk({name, "_hilo_we"}, hilo_we, 1'b1);
            chk({name, "_hi"}, hi_out, exp_hi);
            chk({name, "_lo"}, lo_out, exp_lo);
            @(posedge clk);
            #1;
            chk({name, "_done_1cyc"}, done, 1'b0);
            chk({name, "_we_1cyc"}, hilo_we, 1'b0);
        end
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = 32'h0;
        rt_data = 32'h0;
        repeat (3) @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hilo_we", hilo_we, 1'b0);
        chk("rst_hi", hi_out, 32'h0);
        chk("rst_lo", lo_out, 32'h0);
        chk("rst_state", state_dbg, 2'd0);
        start  = 1'b0;
        reset  = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;

        // model pins against hand-computed literals
        chk("pin_multu", model_res(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("pin_mult", model_res(2'b00, 32'hFFFF_FFFD, 32'h7), 64'hFFFF_FFFF_FFFF_FFEB);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32, 0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32, 0);
        run_op("multu_6x7", 2'b01, 32'h6, 32'h7, 32'h0, 32'h0000_002A, 32, 0);
        run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 32, 0);
        run_op("mult_minx1", 2'b00, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32, 0);
        run_op("mult_zero", 2'b00, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32, 0);
`ifdef MDU_DIV_EN
        chk("pin_div", model_res(2'b10, 32'hFFFF_FFF9, 32'h2), 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_neg7", 2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, 0);
        run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32, 0);
        run_op("divu_by0", 2'b11, 32'h0000_0064, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF, 32, 0);
        run_op("div_7_m2", 2'b10, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 32, 0);
        run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'hA, 32'h5, 32'h1999_9999, 32, 0);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FF9C, 32'h0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32, 0);
`else
        chk("pin_div_off", model_res(2'b11, 32'hA, 32'h3), 64'h0);
        run_op("divu_off", 2'b11, 32'hA, 32'h3, 32'h0, 32'h0, 0, 0);
        run_op("multu_after", 2'b01, 32'h6, 32'h7, 32'h0, 32'h0000_002A, 32, 0);
        run_op("div_off", 2'b10, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, 0, 0);
`endif
        run_op("mult_prime", 2'b00, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32, 0);
        run_op("restart_ign", 2'b01, 32'h6, 32'h7, 32'h0, 32'h0000_002A, 32, 1);
        run_op("mult_prime2", 2'b00, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32, 0);
        run_op("reset_abort", 2'b01, 32'h1234, 32'h5678, 32'h0, 32'h0, 32, 2);
        run_op("after_abort", 2'b01, 32'h6, 32'h7, 32'h0, 32'h0000_002A, 32, 0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
